// File: rtl/ps2_key_assembler.sv
// ps2_key_assembler
//   Assembles the raw PS/2 set-2 scancode byte stream into one 65-bit key
//   event word per completed key action. Event bytes are right-aligned in
//   ps2_key[63:0] with the oldest byte highest. Unused upper bytes are zero.
//   ps2_key[64] toggles once per event.
//
// Ports
//   clk_sys   in   1  system clock, rising edge
//   reset_n   in   1  asynchronous active-low reset
//   rx_data   in   8  received scancode byte
//   rx_valid  in   1  one-cycle strobe qualifying rx_data
//   ps2_key   out 65  [64] event toggle, [63:0] event bytes (last byte in [7:0])
//   key_stb   out  1  one-cycle pulse in the cycle ps2_key updates
//   seq_err   out  1  one-cycle pulse when a partial sequence is dropped
//
// Parameter
//   TIMEOUT_CYC  idle cycles tolerated inside a partial sequence
module ps2_key_assembler #(
  parameter logic [23:0] TIMEOUT_CYC = 24'd1200000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [64:0] ps2_key,
  output logic        key_stb,
  output logic        seq_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PFX    = 3'd1;
  localparam logic [2:0] S_PAUSE  = 3'd2;
  localparam logic [2:0] S_PRT_MK = 3'd3;
  localparam logic [2:0] S_PRT_BK = 3'd4;

  // Result of feeding one byte to the "ordinary" part of the decoder
  // (IDLE / PFX / PAUSE). Used both for the live state and for replaying
  // a byte after an aborted Print Screen sequence.
  typedef struct packed {
    logic [2:0]  state;
    logic [63:0] acc;
    logic [3:0]  cnt;
    logic        emit;
    logic [63:0] data;
    logic        err;
  } step_t;

  function automatic logic f_is_discard(input logic [7:0] b);
    logic d;
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: d = 1'b1;
      default:                                  d = 1'b0;
    endcase
    return d;
  endfunction

  function automatic step_t f_step(input logic [2:0]  st,
                                   input logic [63:0] acc,
                                   input logic [3:0]  cnt,
                                   input logic [7:0]  b);
    step_t       s;
    logic [63:0] acc_sh;
    acc_sh  = {acc[55:0], b};
    s.state = st;
    s.acc   = acc;
    s.cnt   = cnt;
    s.emit  = 1'b0;
    s.data  = '0;
    s.err   = 1'b0;
    case (st)
      S_IDLE: begin
        if (b == 8'hE0 || b == 8'hF0) begin
          s.state = S_PFX;
          s.acc   = {56'd0, b};
          s.cnt   = 4'd1;
        end else if (b == 8'hE1) begin
          s.state = S_PAUSE;
          s.acc   = {56'd0, b};
          s.cnt   = 4'd1;
        end else if (!f_is_discard(b)) begin
          s.emit = 1'b1;
          s.data = {56'd0, b};
        end
      end
      S_PFX: begin
        if (cnt == 4'd8) begin
          // A ninth byte cannot be represented; drop everything.
          s.err   = 1'b1;
          s.state = S_IDLE;
          s.acc   = '0;
          s.cnt   = '0;
        end else if (b == 8'hE0 || b == 8'hF0) begin
          s.acc = acc_sh;
          s.cnt = cnt + 4'd1;
        end else if (b == 8'h12 && acc == 64'hE0) begin
          s.state = S_PRT_MK;
          s.acc   = acc_sh;
          s.cnt   = cnt + 4'd1;
        end else if (b == 8'h7C && acc == 64'hE0F0) begin
          s.state = S_PRT_BK;
          s.acc   = acc_sh;
          s.cnt   = cnt + 4'd1;
        end else begin
          s.emit  = 1'b1;
          s.data  = acc_sh;
          s.state = S_IDLE;
          s.acc   = '0;
          s.cnt   = '0;
        end
      end
      S_PAUSE: begin
        if (cnt == 4'd7) begin
          s.emit  = 1'b1;
          s.data  = acc_sh;
          s.state = S_IDLE;
          s.acc   = '0;
          s.cnt   = '0;
        end else begin
          s.acc = acc_sh;
          s.cnt = cnt + 4'd1;
        end
      end
      default: begin
        s.state = S_IDLE;
        s.acc   = '0;
        s.cnt   = '0;
      end
    endcase
    return s;
  endfunction

  logic [2:0]  r_state;
  logic [63:0] r_acc;
  logic [3:0]  r_cnt;
  logic [23:0] r_timer;
  logic [64:0] r_key;
  logic        r_stb;
  logic        r_err;
  logic        r_defer_vld;
  logic [63:0] r_defer_data;

  logic [2:0]  w_state_next;
  logic [63:0] w_acc_next;
  logic [3:0]  w_cnt_next;
  logic [23:0] w_timer_next;
  logic        w_err_next;
  logic        w_fsm_emit;
  logic [63:0] w_fsm_data;
  logic        w_fsm_defer;
  logic [63:0] w_fsm_defer_data;
  logic        w_out_emit;
  logic [63:0] w_out_data;
  logic        w_defer_vld_next;
  logic [63:0] w_defer_data_next;
  logic        w_restart;
  logic [63:0] w_acc_sh;
  logic [63:0] w_pending;
  logic [7:0]  w_bk_expect;
  logic [2:0]  w_rs_state;
  logic [63:0] w_rs_acc;
  logic [3:0]  w_rs_cnt;
  step_t       w_step;
  step_t       w_rs_step;

  assign w_acc_sh    = {r_acc[55:0], rx_data};
  // Event already committed when a Print Screen sequence is abandoned.
  assign w_pending   = (r_state == S_PRT_MK) ? 64'hE012 : 64'hE0F07C;
  assign w_bk_expect = (r_cnt == 4'd3) ? 8'hE0 : ((r_cnt == 4'd4) ? 8'hF0 : 8'h12);

  // Context the mismatching byte is re-evaluated in after an aborted
  // Print Screen. Trailing E0 / E0 F0 of a partial second half are kept as
  // a fresh prefix so the byte that broke the match is not lost.
  always_comb begin
    w_rs_state = S_IDLE;
    w_rs_acc   = '0;
    w_rs_cnt   = '0;
    if ((r_state == S_PRT_MK && r_cnt == 4'd3) ||
        (r_state == S_PRT_BK && r_cnt == 4'd4)) begin
      w_rs_state = S_PFX;
      w_rs_acc   = 64'hE0;
      w_rs_cnt   = 4'd1;
    end else if (r_state == S_PRT_BK && r_cnt == 4'd5) begin
      w_rs_state = S_PFX;
      w_rs_acc   = 64'hE0F0;
      w_rs_cnt   = 4'd2;
    end
  end

  assign w_step    = f_step(r_state, r_acc, r_cnt, rx_data);
  assign w_rs_step = f_step(w_rs_state, w_rs_acc, w_rs_cnt, rx_data);

  always_comb begin
    w_state_next     = r_state;
    w_acc_next       = r_acc;
    w_cnt_next       = r_cnt;
    w_timer_next     = r_timer;
    w_err_next       = 1'b0;
    w_fsm_emit       = 1'b0;
    w_fsm_data       = '0;
    w_fsm_defer      = 1'b0;
    w_fsm_defer_data = '0;
    w_restart        = 1'b0;

    if (rx_valid) begin
      // A byte always wins over a coinciding timeout.
      w_timer_next = '0;
      case (r_state)
        S_PRT_MK: begin
          if (r_cnt == 4'd2 && rx_data == 8'hE0) begin
            w_acc_next = w_acc_sh;
            w_cnt_next = r_cnt + 4'd1;
          end else if (r_cnt == 4'd3 && rx_data == 8'h7C) begin
            w_fsm_emit   = 1'b1;
            w_fsm_data   = w_acc_sh;
            w_state_next = S_IDLE;
            w_acc_next   = '0;
            w_cnt_next   = '0;
          end else begin
            w_restart = 1'b1;
          end
        end
        S_PRT_BK: begin
          if (rx_data == w_bk_expect) begin
            if (r_cnt == 4'd5) begin
              w_fsm_emit   = 1'b1;
              w_fsm_data   = w_acc_sh;
              w_state_next = S_IDLE;
              w_acc_next   = '0;
              w_cnt_next   = '0;
            end else begin
              w_acc_next = w_acc_sh;
              w_cnt_next = r_cnt + 4'd1;
            end
          end else begin
            w_restart = 1'b1;
          end
        end
        default: begin
          w_state_next = w_step.state;
          w_acc_next   = w_step.acc;
          w_cnt_next   = w_step.cnt;
          w_fsm_emit   = w_step.emit;
          w_fsm_data   = w_step.data;
          w_err_next   = w_step.err;
        end
      endcase

      if (w_restart) begin
        // Emit the committed part now; if the replayed byte also completes
        // an event, hold that one for the following cycle.
        w_fsm_emit       = 1'b1;
        w_fsm_data       = w_pending;
        w_state_next     = w_rs_step.state;
        w_acc_next       = w_rs_step.acc;
        w_cnt_next       = w_rs_step.cnt;
        w_fsm_defer      = w_rs_step.emit;
        w_fsm_defer_data = w_rs_step.data;
        w_err_next       = w_rs_step.err;
      end
    end else if (r_state != S_IDLE) begin
      if (r_timer == TIMEOUT_CYC - 24'd1) begin
        w_timer_next = '0;
        w_state_next = S_IDLE;
        w_acc_next   = '0;
        w_cnt_next   = '0;
        if (r_state == S_PRT_MK || r_state == S_PRT_BK) begin
          w_fsm_emit = 1'b1;
          w_fsm_data = w_pending;
        end else begin
          w_err_next = 1'b1;
        end
      end else begin
        w_timer_next = r_timer + 24'd1;
      end
    end else begin
      w_timer_next = '0;
    end
  end

  // A deferred event is only ever pending while in IDLE, so the only
  // possible collision is with a new single-byte event: emit the older one
  // and queue the newer one behind it.
  always_comb begin
    w_out_emit        = w_fsm_emit;
    w_out_data        = w_fsm_data;
    w_defer_vld_next  = w_fsm_defer;
    w_defer_data_next = w_fsm_defer_data;
    if (r_defer_vld) begin
      w_out_emit = 1'b1;
      w_out_data = r_defer_data;
      if (w_fsm_emit) begin
        w_defer_vld_next  = 1'b1;
        w_defer_data_next = w_fsm_data;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_timer      <= '0;
      r_key        <= '0;
      r_stb        <= 1'b0;
      r_err        <= 1'b0;
      r_defer_vld  <= 1'b0;
      r_defer_data <= '0;
    end else begin
      r_state      <= w_state_next;
      r_acc        <= w_acc_next;
      r_cnt        <= w_cnt_next;
      r_timer      <= w_timer_next;
      r_stb        <= w_out_emit;
      r_err        <= w_err_next;
      r_defer_vld  <= w_defer_vld_next;
      r_defer_data <= w_defer_data_next;
      if (w_out_emit) begin
        r_key <= {~r_key[64], w_out_data};
      end
    end
  end

  assign ps2_key = r_key;
  assign key_stb = r_stb;
  assign seq_err = r_err;

endmodule

// File: tb/tb_ps2_key_assembler.sv
module tb_ps2_key_assembler;

  localparam logic [23:0] TMO = 24'd40;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [64:0] ps2_key;
  logic        key_stb;
  logic        seq_err;

  ps2_key_assembler #(.TIMEOUT_CYC(TMO)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .ps2_key (ps2_key),
    .key_stb (key_stb),
    .seq_err (seq_err)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic        is_err;
    logic [63:0] data;
  } exp_t;

  exp_t         expq[$];
  byte unsigned seq[$];   // bytes of the partial sequence the model holds
  int           checks = 0;
  int           errors = 0;

  // ---------------- reference model ----------------
  function automatic logic [63:0] seq_value();
    logic [63:0] v;
    v = '0;
    foreach (seq[i]) v = {v[55:0], seq[i]};
    return v;
  endfunction

  // 1: held bytes begin E0 12 (Print Screen make), 2: begin E0 F0 7C (break)
  function automatic int prt_kind();
    if (seq.size() >= 3 && seq[0] == 8'hE0 && seq[1] == 8'hF0 && seq[2] == 8'h7C) return 2;
    if (seq.size() >= 2 && seq[0] == 8'hE0 && seq[1] == 8'h12) return 1;
    return 0;
  endfunction

  task automatic push_evt(input logic [63:0] d);
    exp_t e;
    e.is_err = 1'b0;
    e.data   = d;
    expq.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1;
    e.data   = '0;
    expq.push_back(e);
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit           again;
    byte unsigned pat[$];
    int           keep;
    logic [63:0]  pend;
    again = 1'b1;
    while (again) begin
      again = 1'b0;
      if (seq.size() == 0) begin
        if (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF}) begin
        end else if (b inside {8'hE0, 8'hF0, 8'hE1}) begin
          seq.push_back(b);
        end else begin
          push_evt({56'd0, b});
        end
      end else if (seq[0] == 8'hE1) begin
        seq.push_back(b);
        if (seq.size() == 8) begin
          push_evt(seq_value());
          seq.delete();
        end
      end else if (prt_kind() != 0) begin
        if (prt_kind() == 1) begin
          pat = '{8'hE0, 8'h12, 8'hE0, 8'h7C};
          keep = 2; pend = 64'hE012;
        end else begin
          pat = '{8'hE0, 8'hF0, 8'h7C, 8'hE0, 8'hF0, 8'h12};
          keep = 3; pend = 64'hE0F07C;
        end
        if (b == pat[seq.size()]) begin
          seq.push_back(b);
          if (seq.size() == pat.size()) begin
            push_evt(seq_value());
            seq.delete();
          end
        end else begin
          // Committed part goes out; leftover bytes become a fresh start.
          push_evt(pend);
          repeat (keep) void'(seq.pop_front());
          again = 1'b1;
        end
      end else begin
        if (seq.size() == 8) begin
          push_err();
          seq.delete();
        end else if (b == 8'hE0 || b == 8'hF0) begin
          seq.push_back(b);
        end else begin
          seq.push_back(b);
          if (prt_kind() == 0) begin
            push_evt(seq_value());
            seq.delete();
          end
        end
      end
    end
  endtask

  task automatic model_timeout();
    if (seq.size() != 0) begin
      if (prt_kind() == 1)      push_evt(64'hE012);
      else if (prt_kind() == 2) push_evt(64'hE0F07C);
      else                      push_err();
      seq.delete();
    end
  endtask

  // ---------------- stimulus helpers ----------------
  // Called at #1 after a rising edge; returns at #1 after a rising edge.
  // gap = number of edges with rx_valid low before the next strobe can start.
  task automatic send(input logic [7:0] b, input int gap);
    model_byte(b);
    if (gap >= int'(TMO)) model_timeout();
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk_sys); #1;
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk_sys); #1; end
  endtask

  task automatic chk(input string name, input logic [64:0] got, input logic [64:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] pick_byte();
    int r;
    r = $urandom_range(0, 15);
    case (r)
      0, 1, 2: return 8'hE0;
      3:       return 8'hF0;
      4:       return 8'hE1;
      5:       return 8'h12;
      6:       return 8'h7C;
      7:       return 8'hFA;
      default: return 8'($urandom_range(1, 254));
    endcase
  endfunction

  function automatic int pick_gap();
    int g;
    g = $urandom_range(0, 24);
    if (g == 0) return int'(TMO) - 1;
    if (g == 1) return int'(TMO);
    return g % 5;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic        exp_tog;
    logic [63:0] last_key;
    exp_t        e;
    exp_tog  = 1'b0;
    last_key = '0;
    forever begin
      @(negedge clk_sys);
      if (!reset_n) begin
        exp_tog  = 1'b0;
        last_key = '0;
        chk("reset_outputs", {ps2_key[64:2], key_stb, seq_err}, '0);
      end else if (key_stb || seq_err) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output stb=%0d err=%0d key=%h", key_stb, seq_err, ps2_key);
        end else begin
          e = expq.pop_front();
          if (e.is_err) begin
            if (!seq_err || key_stb || ps2_key !== {exp_tog, last_key}) begin
              errors++;
              $display("FAIL seq_err_event stb=%0d err=%0d key=%h required err=1 key=%h",
                       key_stb, seq_err, ps2_key, {exp_tog, last_key});
            end else begin
              $display("seq_err  key=%h", ps2_key);
            end
          end else begin
            exp_tog  = ~exp_tog;
            last_key = e.data;
            if (!key_stb || seq_err || ps2_key !== {exp_tog, last_key}) begin
              errors++;
              $display("FAIL key_event stb=%0d err=%0d key=%h required key=%h",
                       key_stb, seq_err, ps2_key, {exp_tog, last_key});
            end else begin
              $display("event    key=%h", ps2_key);
            end
          end
        end
      end else begin
        chk("key_hold", ps2_key, {exp_tog, last_key});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired pending=%0d", expq.size());
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("reset_key", ps2_key, '0);
    chk("reset_stb", {64'd0, key_stb}, '0);
    chk("reset_err", {64'd0, seq_err}, '0);
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
    @(posedge clk_sys); #1;

    // make / break of a plain key
    send(8'h29, 4);
    chk("make_29", ps2_key, {1'b1, 64'h29});
    send(8'hF0, 2); send(8'h29, 4);
    chk("break_29", ps2_key, {1'b0, 64'hF029});

    // extended key, derived pressed/extended flags
    send(8'hE0, 2); send(8'h75, 4);
    chk("ext_make_pressed",  {64'd0, ps2_key[15:8] != 8'hF0}, 65'd1);
    chk("ext_make_extended", {64'd0, ps2_key[15:8] == 8'hE0}, 65'd1);
    send(8'hE0, 2); send(8'hF0, 2); send(8'h75, 4);
    chk("ext_brk_pressed",  {64'd0, ps2_key[15:8] != 8'hF0}, 65'd0);
    chk("ext_brk_extended", {64'd0, ps2_key[23:16] == 8'hE0}, 65'd1);

    // Pause
    send(8'hE1, 1); send(8'h14, 1); send(8'h77, 1); send(8'hE1, 1);
    send(8'hF0, 1); send(8'h14, 1); send(8'hF0, 1); send(8'h77, 4);
    chk("pause", ps2_key[63:0], 64'hE11477E1F014F077);

    // Print Screen make and break
    send(8'hE0, 1); send(8'h12, 1); send(8'hE0, 1); send(8'h7C, 4);
    chk("prt_make", ps2_key[63:0], 64'hE012E07C);
    send(8'hE0, 1); send(8'hF0, 1); send(8'h7C, 1);
    send(8'hE0, 1); send(8'hF0, 1); send(8'h12, 4);
    chk("prt_break", ps2_key[63:0], 64'h0000E0F07CE0F012);

    // aborted Print Screen, back-to-back and spaced
    send(8'hE0, 1); send(8'h12, 0); send(8'h1C, 0); send(8'h2A, 4);
    chk("prt_abort_chain", ps2_key[63:0], 64'h2A);
    send(8'hE0, 1); send(8'h12, 1); send(8'hE0, 1); send(8'h5A, 4);
    chk("prt_abort_e0", ps2_key[63:0], 64'hE05A);

    // discard byte, timeouts and the boundary around them
    send(8'hFA, 4);
    chk("discard_fa", ps2_key[63:0], 64'hE05A);
    send(8'hE0, int'(TMO) + 2); send(8'h29, 4);
    chk("after_timeout", ps2_key[63:0], 64'h29);
    send(8'hE0, int'(TMO) - 1); send(8'h29, 4);
    chk("no_timeout_edge", ps2_key[63:0], 64'hE029);
    send(8'hE0, 1); send(8'h12, int'(TMO) + 2);
    chk("prt_mk_timeout", ps2_key[63:0], 64'hE012);
    send(8'hE0, 1); send(8'hF0, 1); send(8'h7C, 1); send(8'hE0, int'(TMO) + 2);
    chk("prt_bk_timeout", ps2_key[63:0], 64'hE0F07C);

    // length guard: eight prefixes then a ninth byte
    repeat (8) send(8'hE0, 1);
    send(8'h29, 3);
    send(8'h16, 4);
    chk("after_guard", ps2_key[63:0], 64'h16);

    // asynchronous reset in the middle of Pause
    send(8'hE1, 2); send(8'h14, 2); send(8'h77, 4);
    reset_n = 1'b0;
    seq.delete();
    @(negedge clk_sys);
    chk("midseq_reset_key", ps2_key, '0);
    chk("midseq_reset_pulses", {63'd0, key_stb, seq_err}, '0);
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
    @(posedge clk_sys); #1;
    send(8'h29, 4);
    chk("post_reset_29", ps2_key, {1'b1, 64'h29});

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      int sel;
      sel = $urandom_range(0, 11);
      case (sel)
        0: begin
          send(8'hE1, pick_gap()); send(8'h14, pick_gap()); send(8'h77, pick_gap());
          send(8'hE1, pick_gap()); send(8'hF0, pick_gap()); send(8'h14, pick_gap());
          send(8'hF0, pick_gap()); send(8'h77, pick_gap());
        end
        1: begin
          send(8'hE0, pick_gap()); send(8'h12, pick_gap());
          send(8'hE0, pick_gap()); send(8'h7C, pick_gap());
        end
        2: begin
          send(8'hE0, pick_gap()); send(8'hF0, pick_gap()); send(8'h7C, pick_gap());
          send(8'hE0, pick_gap()); send(8'hF0, pick_gap()); send(8'h12, pick_gap());
        end
        default: send(pick_byte(), pick_gap());
      endcase
    end

    // let any partial sequence expire, then drain the scoreboard
    model_timeout();
    repeat (int'(TMO) + 8) @(posedge clk_sys);
    for (int i = 0; i < 200 && expq.size() != 0; i++) @(posedge clk_sys);
    @(negedge clk_sys);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL missing_events outstanding=%0d required=0", expq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_assembler.md
Name: ps2_key_assembler

Overview:
- Converts the raw PS/2 set-2 scancode byte stream from the keyboard receiver into the 65-bit ps2_key event word.
- The core-side key decoders in clk_sys consume that word.
- Each completed key event is latched into ps2_key[63:0] with its bytes right-aligned, oldest byte highest, unused bytes zero. ps2_key[64] toggles once per event.
- Sits between the PS/2 byte receiver and every emu-level keyboard consumer.

Parameters:
- TIMEOUT_CYC, 24'd1200000: idle clk_sys cycles allowed inside a partial sequence before it is discarded. Default is about 100 ms at 12 MHz.

Ports:
- clk_sys  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rx_data  in  8  received scancode byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid on this cycle.
- ps2_key  out  65  [64] event toggle; [63:0] event bytes, last byte in [7:0].
- key_stb  out  1  one-cycle pulse in the same cycle ps2_key updates.
- seq_err  out  1  one-cycle pulse when a partial sequence is dropped (timeout or length overflow).

Behaviour:
- Reset: ps2_key=0, key_stb=0, seq_err=0, accumulator=0, byte count=0, timer=0, state=IDLE.
- Accumulator acc[63:0] shifts left by 8 per accepted byte: acc <= {acc[55:0],rx_data}. A new event starts with acc cleared.
- Event emit, registered, takes effect the cycle after the completing rx_valid:
  - ps2_key[63:0] <= completed acc
  - ps2_key[64] inverts
  - key_stb=1 for one cycle
  - state returns to IDLE
- Prefix bytes: E0, F0, E1.
- Discarded bytes in IDLE: 00, AA, EE, FA, FE, FF. These are controller/BAT responses and produce no event.
- States:
  - IDLE
    - E0 or F0 -> PFX.
    - E1 -> PAUSE with count=1.
    - Discard byte -> stay in IDLE.
    - Any other byte -> emit single-byte event.
  - PFX
    - E0 or F0 -> stay in PFX.
    - Byte 12 when acc=E0 -> PRT_MK.
    - Byte 7C when acc=E0F0 -> PRT_BK.
    - Any other byte -> emit.
  - PAUSE
    - Accept any byte; count+1.
    - On the 8th byte, emit. Pause = E1 14 77 E1 F0 14 F0 77 and fills all of [63:0].
  - PRT_MK, for sequence E0 12 E0 7C
    - Expects E0 then 7C. Completion emits E0127C... as a 4-byte event, i.e. 32'hE012E07C.
    - If the byte after E0 12 is not E0: emit the pending E0 12 event, and in the same cycle restart the accumulator with the new byte, processed as if from IDLE.
    - If E0 is followed by anything other than 7C: emit E0 12, then continue as PFX with acc={E0,byte} evaluated.
  - PRT_BK, for sequence E0 F0 7C E0 F0 12
    - Expects E0, F0, 12 and emits the 6-byte event.
    - A mismatch emits the pending E0 F0 7C event and restarts with the new byte as in PRT_MK.
- Length guard: a 9th byte without completion (not reachable by legal sequences) sets seq_err, clears acc and returns to IDLE. The byte is dropped.
- Timeout:
  - Timer clears on every rx_valid and counts only while state != IDLE.
  - On reaching TIMEOUT_CYC: seq_err pulses, acc clears, state=IDLE, no event.
  - Exception: in PRT_MK/PRT_BK, timeout emits the pending event (E0 12 or E0 F0 7C) instead of seq_err.
- ps2_key holds its value between events. Consumers detect events via the ps2_key[64] edge.
- rx_valid in the same cycle as a timeout expiry: the byte wins, the timer clears, and there is no timeout.
- Async reset mid-sequence clears everything. No event is emitted, and ps2_key[64] returns to 0.
- Decoding invariants consumers rely on:
  - pressed  = ps2_key[15:8] != F0
  - extended = pressed ? ps2_key[15:8]==E0 : ps2_key[23:16]==E0
  - ps2_key[63:24] is nonzero only for Print Screen or Pause.

Test Plan:
- Bytes 29, then F0 29 -> two events, ps2_key[63:0]=0x29 then 0xF029. Bit 64 goes 0->1->0, with two key_stb pulses.
- E0 75, then E0 F0 75 -> events 0xE075 and 0xE0F075. Derived pressed=1,extended=1 then pressed=0,extended=1.
- Pause E1 14 77 E1 F0 14 F0 77 -> exactly one event, [63:0]=0xE11477E1F014F077, no intermediate key_stb.
- E0 12 E0 7C -> one event 0xE012E07C. E0 F0 7C E0 F0 12 -> one event 0x0000E0F07CE0F012.
- E0 12 then 1C -> event 0xE012 then event 0x1C, in consecutive emits.
- Byte FA -> no event. E0 then silence for TIMEOUT_CYC -> seq_err pulse, no event; next byte 29 -> event 0x29 with upper bytes zero.
- reset_n low during E1 14 77 -> all outputs 0. Following 29 -> event 0x29, bit 64=1.
